mult_div_unit: RTL
==================

// Module: mult_div_unit
// PURPOSE
//  Multi-cycle multiply/divide unit fed by the ID_EX stage's Start, op, A and B outputs.
//  Owns the HI/LO registers and returns Busy/Stall to the hazard logic.
//  Hazard logic uses Stall to hold IF_ID (IF_ID_En=0) and bubble ID_EX while an MD op is in flight.
// PARAMETERS
//  MULT_CYCLES  5   Busy cycles for mult/multu (and madd/maddu); legal range 1..15
//  DIV_CYCLES   10  Busy cycles for div/divu; legal range 1..15
// PORTS
//  clk     in   1   rising-edge clock
//  reset   in   1   synchronous, active-high reset
//  Start   in   1   one-cycle strobe; MDOp/A/B are valid in this cycle
//  MDOp    in   3   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd/maddu
//  MDSign  in   1   for MDOp=7 only: 1 madd (signed), 0 maddu (unsigned)
//  A       in   32  rs operand (source for mthi/mtlo)
//  B       in   32  rt operand
//  Busy    out  1   registered; high while an operation is in flight
//  Stall   out  1   combinational: Busy | (Start & MDOp in {1,2,3,4,7})
//  HI      out  32  HI register
//  LO      out  32  LO register
// BEHAVIOUR
//  - Reset: Busy=0, HI=0, LO=0, counter=0, pending result=0, state=IDLE.
//  - FSM states
//    - IDLE -> RUN on Start with MDOp in {1,2,3,4,7}.
//    - RUN -> IDLE when the counter reaches 1.
//  - Capture: on the Start edge, the 64-bit result is computed from A/B and held in pend_hi/pend_lo.
//    - Counter loads MULT_CYCLES for 1,2,7 and DIV_CYCLES for 3,4.
//  - Timing: Start in cycle t -> Busy=1 in cycles t+1..t+N.
//    - On the edge closing cycle t+N: HI/LO <= pending values, Busy <= 0.
//    - New HI/LO are visible from cycle t+N+1.
//    - HI/LO keep their old values throughout RUN.
//  - Arithmetic:
//    - mult: signed 32x32->64, HI=prod[63:32], LO=prod[31:0]. multu: same, unsigned.
//    - div: LO=quotient truncated toward zero, HI=remainder with the sign of the dividend. divu: unsigned.
//    - Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
//    - Divide by zero: full DIV_CYCLES Busy period still runs; HI/LO end unchanged.
//  - mthi/mtlo in IDLE: HI (resp. LO) <= A on the Start edge. No Busy, Stall=0.
//  - Start while Busy: ignored entirely (no capture, no HI/LO write, counter undisturbed).
//    - Upstream guarantees this does not happen; the unit still tolerates it.
//  - MDOp=0 with Start, or MDOp=7 without the macro: no effect.
//  - Reset mid-operation (reset has priority over all): IDLE, Busy=0, HI=LO=0, pending result discarded.
//  - Reads of HI/LO (mfhi/mflo) are the consumer's concern and must stall on Stall.
// CONFIGURATION
//  - MDU_MADD_EN defined:
//    - MDOp=7 accepted with MULT_CYCLES latency.
//    - {HI,LO} <= {HI,LO} + A*B (signed if MDSign=1, else unsigned), mod 2^64.
//    - The accumulator base is HI/LO sampled at the Start edge.
//  - MDU_MADD_EN undefined: MDOp=7 is a no-op; Stall excludes MDOp=7; no accumulator logic is built.
// TESTING
//  - mult A=3 B=0xFFFFFFFE
//    -> Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
//    -> During Busy, HI/LO hold their prior values.
//  - divu A=7 B=2 -> Busy 10 cycles; LO=3, HI=1.
//    div A=0xFFFFFFF9 (-7) B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//  - div A=0x80000000 B=0xFFFFFFFF -> LO=0x80000000, HI=0.
//    div A=5 B=0 -> 10 Busy cycles, HI/LO unchanged.
//  - mthi A=0x12345678 in IDLE -> HI=0x12345678 next cycle, Busy stays 0.
//    Same mthi issued mid-mult -> ignored; mult result lands as normal.
//  - Start mult, assert reset in the 3rd Busy cycle -> next cycle Busy=0, HI=LO=0.
//    A following mult completes normally.
//  - MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, maddu A=1 B=1 -> after 5 cycles HI=1, LO=0.
//    Without the macro: same stimulus leaves HI/LO unchanged and Stall=0.

Source files
------------

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle multiply/divide unit that owns the HI/LO registers.
// Operands are captured when Start is seen and the 64-bit result is computed then.
// That result is held as pending until the Busy window closes, and only then
// committed to HI/LO.
// Optional feature macro: MDU_MADD_EN adds madd/maddu (MDOp=7) accumulation into HI/LO.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic        MDSign,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic        Stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
`ifdef MDU_MADD_EN
    localparam logic [2:0] OP_MADD  = 3'd7;
`endif

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, next_state;
    logic [3:0]  cnt, next_cnt;
    logic [31:0] hi_reg, next_hi;
    logic [31:0] lo_reg, next_lo;
    logic [31:0] pend_hi, next_pend_hi;
    logic [31:0] pend_lo, next_pend_lo;

    logic        md_op;
    logic        accept;
    logic        is_mult_class;
    logic [63:0] sprod;
    logic [63:0] uprod;
    logic [31:0] a_mag, b_mag;
    logic [31:0] sq_mag, sr_mag;
    logic [31:0] squot, srem;
    logic [31:0] uquot, urem;
    logic [63:0] result;

    // Multi-cycle operations; madd only exists when the accumulator is built
`ifdef MDU_MADD_EN
    assign md_op = (MDOp == OP_MULT) || (MDOp == OP_MULTU) || (MDOp == OP_DIV) ||
                   (MDOp == OP_DIVU) || (MDOp == OP_MADD);
    assign is_mult_class = (MDOp == OP_MULT) || (MDOp == OP_MULTU) || (MDOp == OP_MADD);
`else
    logic unused_sign;
    assign unused_sign = MDSign;
    assign md_op = (MDOp == OP_MULT) || (MDOp == OP_MULTU) || (MDOp == OP_DIV) ||
                   (MDOp == OP_DIVU);
    assign is_mult_class = (MDOp == OP_MULT) || (MDOp == OP_MULTU);
`endif

    // A Start that arrives while busy is dropped on the floor
    assign accept = Start && (state == IDLE) && md_op;
    assign Busy   = (state == RUN);
    assign Stall  = Busy | (Start & md_op);
    assign HI     = hi_reg;
    assign LO     = lo_reg;

    // Full-width products from explicitly extended operands
    assign sprod = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign uprod = {32'd0, A} * {32'd0, B};

    // Signed divide through magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0
    assign a_mag  = A[31] ? (~A + 32'd1) : A;
    assign b_mag  = B[31] ? (~B + 32'd1) : B;
    assign sq_mag = a_mag / b_mag;
    assign sr_mag = a_mag % b_mag;
    assign squot  = (A[31] ^ B[31]) ? (~sq_mag + 32'd1) : sq_mag;
    assign srem   = A[31] ? (~sr_mag + 32'd1) : sr_mag;
    assign uquot  = A / B;
    assign urem   = A % B;

    // Result to park in the pending registers; divide by zero keeps HI/LO as they are
    always_comb begin
        result = {hi_reg, lo_reg};
        case (MDOp)
            OP_MULT:  result = sprod;
            OP_MULTU: result = uprod;
            OP_DIV:   if (B != 32'd0) result = {srem, squot};
            OP_DIVU:  if (B != 32'd0) result = {urem, uquot};
`ifdef MDU_MADD_EN
            OP_MADD:  result = {hi_reg, lo_reg} + (MDSign ? sprod : uprod);
`endif
            default:  result = {hi_reg, lo_reg};
        endcase
    end

    // Next-state logic: capture in IDLE, count down in RUN, commit on the last count
    always_comb begin
        next_state   = state;
        next_cnt     = cnt;
        next_hi      = hi_reg;
        next_lo      = lo_reg;
        next_pend_hi = pend_hi;
        next_pend_lo = pend_lo;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state   = RUN;
                    next_cnt     = is_mult_class ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
                    next_pend_hi = result[63:32];
                    next_pend_lo = result[31:0];
                end else if (Start && (MDOp == OP_MTHI)) begin
                    next_hi = A;
                end else if (Start && (MDOp == OP_MTLO)) begin
                    next_lo = A;
                end
            end
            RUN: begin
                if (cnt <= 4'd1) begin
                    next_state = IDLE;
                    next_cnt   = 4'd0;
                    next_hi    = pend_hi;
                    next_lo    = pend_lo;
                end else begin
                    next_cnt = cnt - 4'd1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State and data registers; reset wins over everything, including a pending result
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            hi_reg  <= 32'd0;
            lo_reg  <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
        end else begin
            state   <= next_state;
            cnt     <= next_cnt;
            hi_reg  <= next_hi;
            lo_reg  <= next_lo;
            pend_hi <= next_pend_hi;
            pend_lo <= next_pend_lo;
        end
    end

endmodule
